// File: rtl/ansi_colour_streamer.sv
// Wraps each message in ANSI SGR colour escapes (ESC [ 3x/9x m ... ESC [ 0 m).
// Optional background colour field enabled by defining ANSI_BG_EN.
module ansi_colour_streamer #(
  parameter int unsigned DEFAULT_COLOUR = 7,
  parameter bit          EMIT_RESET     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [2:0] s_colour,
  input  logic       s_bright,
  input  logic       s_mode,
`ifdef ANSI_BG_EN
  input  logic [2:0] s_bg_colour,
  input  logic       s_bg_en,
`endif
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] P_ESC   = 4'd1;
  localparam logic [3:0] P_LBR   = 4'd2;
  localparam logic [3:0] P_TENS  = 4'd3;
  localparam logic [3:0] P_ONES  = 4'd4;
  localparam logic [3:0] P_M     = 4'd5;
  localparam logic [3:0] PAYLOAD = 4'd6;
  localparam logic [3:0] R_ESC   = 4'd7;
  localparam logic [3:0] R_LBR   = 4'd8;
  localparam logic [3:0] R_ZERO  = 4'd9;
  localparam logic [3:0] R_M     = 4'd10;
`ifdef ANSI_BG_EN
  localparam logic [3:0] P_SEMI  = 4'd11;
  localparam logic [3:0] P_BG4   = 4'd12;
  localparam logic [3:0] P_BGD   = 4'd13;
`endif

  localparam logic [2:0] DEF_C = 3'(DEFAULT_COLOUR);

  logic [3:0] state, nstate;
  logic [2:0] colour;
  logic       bright;
  logic       load_en, emit, hdr_ld;
  logic [7:0] obyte;
`ifdef ANSI_BG_EN
  logic [2:0] bg_colour;
  logic       bg_on;
`endif

  // Output register may take a new byte when empty or when its byte leaves.
  assign load_en = !m_valid || m_ready;
  assign s_ready = (state == PAYLOAD) && load_en;

  always_comb begin
    nstate = state;
    emit   = 1'b0;
    obyte  = 8'h00;
    hdr_ld = 1'b0;
    case (state)
      IDLE: if (s_valid && load_en) begin
        hdr_ld = 1'b1;
        nstate = P_ESC;
      end
      P_ESC: if (load_en) begin
        emit = 1'b1; obyte = 8'h1B; nstate = P_LBR;
      end
      P_LBR: if (load_en) begin
        emit = 1'b1; obyte = 8'h5B; nstate = P_TENS;
      end
      P_TENS: if (load_en) begin
        emit = 1'b1; obyte = bright ? 8'h39 : 8'h33; nstate = P_ONES;
      end
      P_ONES: if (load_en) begin
        emit = 1'b1; obyte = 8'h30 + {5'd0, colour};
`ifdef ANSI_BG_EN
        nstate = bg_on ? P_SEMI : P_M;
`else
        nstate = P_M;
`endif
      end
`ifdef ANSI_BG_EN
      P_SEMI: if (load_en) begin
        emit = 1'b1; obyte = 8'h3B; nstate = P_BG4;
      end
      P_BG4: if (load_en) begin
        emit = 1'b1; obyte = 8'h34; nstate = P_BGD;
      end
      P_BGD: if (load_en) begin
        emit = 1'b1; obyte = 8'h30 + {5'd0, bg_colour}; nstate = P_M;
      end
`endif
      P_M: if (load_en) begin
        emit = 1'b1; obyte = 8'h6D; nstate = PAYLOAD;
      end
      PAYLOAD: if (s_valid && load_en) begin
        emit = 1'b1; obyte = s_data;
        if (s_last) nstate = EMIT_RESET ? R_ESC : IDLE;
      end
      R_ESC: if (load_en) begin
        emit = 1'b1; obyte = 8'h1B; nstate = R_LBR;
      end
      R_LBR: if (load_en) begin
        emit = 1'b1; obyte = 8'h5B; nstate = R_ZERO;
      end
      R_ZERO: if (load_en) begin
        emit = 1'b1; obyte = 8'h30; nstate = R_M;
      end
      R_M: if (load_en) begin
        emit = 1'b1; obyte = 8'h6D; nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      colour  <= 3'd0;
      bright  <= 1'b0;
`ifdef ANSI_BG_EN
      bg_colour <= 3'd0;
      bg_on     <= 1'b0;
`endif
    end else begin
      state <= nstate;
      // m_valid only falls when a slot opens and nothing new is loaded.
      if (load_en) begin
        m_valid <= emit;
        if (emit) m_data <= obyte;
      end
      if (hdr_ld) begin
        colour <= s_mode ? s_colour : DEF_C;
        bright <= s_mode & s_bright;
`ifdef ANSI_BG_EN
        bg_colour <= s_bg_colour;
        bg_on     <= s_mode & s_bg_en;
`endif
      end
    end
  end

endmodule
